// File: rtl/alu_pkg.sv
// Shared constants and payload types for the EX-stage ALU issue unit.
package alu_pkg;

    localparam int unsigned W    = 32;
    localparam int unsigned REGW = 5;

    // ALU control encodings
    localparam logic [2:0] ALU_AND  = 3'd0;
    localparam logic [2:0] ALU_OR   = 3'd1;
    localparam logic [2:0] ALU_ADD  = 3'd2;
    localparam logic [2:0] ALU_SLT  = 3'd3;
    localparam logic [2:0] ALU_ADDU = 3'd4;
    localparam logic [2:0] ALU_SLL  = 3'd5;
    localparam logic [2:0] ALU_SUB  = 3'd6;
    localparam logic [2:0] ALU_SLTU = 3'd7;

    // MIPS opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;

    // MIPS R-type funct codes
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    // Source of the B operand
    typedef enum logic [1:0] {
        EXT_NONE = 2'd0,
        EXT_SEXT = 2'd1,
        EXT_ZEXT = 2'd2
    } ext_e;

    // Issue register (S0) contents
    typedef struct packed {
        logic [2:0]      ctrl;
        logic [W-1:0]    a;
        logic [W-1:0]    b;
        logic [4:0]      shamt;
        logic [REGW-1:0] dest;
        logic            trap_en;
        logic            illegal;
    } s0_t;

    // Result register (S1) contents
    typedef struct packed {
        logic [W-1:0]    result;
        logic [REGW-1:0] dest;
        logic            zero;
        logic            cout;
        logic            ovf_trap;
        logic            illegal;
    } s1_t;

endpackage

// File: rtl/alu_issue_unit_decode.sv
// Combinational decode of opcode/funct into ALU control and operand selection.
module alu_decode
    import alu_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output logic [2:0] ctrl,
    output ext_e       ext,
    output logic       use_shamt,
    output logic       trap_en,
    output logic       illegal
);

    // Decode table; anything unlisted is illegal and yields ctrl 0
    always_comb begin
        ctrl      = ALU_AND;
        ext       = EXT_NONE;
        use_shamt = 1'b0;
        trap_en   = 1'b0;
        illegal   = 1'b0;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    FN_AND:  ctrl = ALU_AND;
                    FN_OR:   ctrl = ALU_OR;
                    FN_ADD:  begin ctrl = ALU_ADD; trap_en = 1'b1; end
                    FN_ADDU: ctrl = ALU_ADDU;
                    FN_SUB:  begin ctrl = ALU_SUB; trap_en = 1'b1; end
                    FN_SUBU: ctrl = ALU_SUB;
                    FN_SLT:  ctrl = ALU_SLT;
                    FN_SLTU: ctrl = ALU_SLTU;
                    FN_SLL:  begin ctrl = ALU_SLL; use_shamt = 1'b1; end
                    default: illegal = 1'b1;
                endcase
            end
            OP_ADDI:  begin ctrl = ALU_ADD;  ext = EXT_SEXT; trap_en = 1'b1; end
            OP_ADDIU: begin ctrl = ALU_ADDU; ext = EXT_SEXT; end
            OP_ANDI:  begin ctrl = ALU_AND;  ext = EXT_ZEXT; end
            OP_ORI:   begin ctrl = ALU_OR;   ext = EXT_ZEXT; end
            OP_SLTI:  begin ctrl = ALU_SLT;  ext = EXT_SEXT; end
            OP_SLTIU: begin ctrl = ALU_SLTU; ext = EXT_SEXT; end
            OP_BEQ,
            OP_BNE:   ctrl = ALU_SUB;
            default:  illegal = 1'b1;
        endcase
        if (illegal) begin
            ctrl      = ALU_AND;
            ext       = EXT_NONE;
            use_shamt = 1'b0;
            trap_en   = 1'b0;
        end
    end

endmodule

// File: rtl/alu_issue_unit.sv
// EX-stage ALU issue unit: ID handshake -> S0 (drives ALU) -> S1 (result) -> MEM/WB handshake.
module alu_issue_unit
    import alu_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [5:0]      in_op,
    input  logic [5:0]      in_funct,
    input  logic [W-1:0]    in_rs_val,
    input  logic [W-1:0]    in_rt_val,
    input  logic [15:0]     in_imm,
    input  logic [4:0]      in_shamt,
    input  logic [REGW-1:0] in_dest,
    output logic [2:0]      alu_ctrl,
    output logic [W-1:0]    alu_a,
    output logic [W-1:0]    alu_b,
    output logic [4:0]      alu_shamt,
    input  logic [W-1:0]    alu_r,
    input  logic            alu_cout,
    input  logic            alu_ovf,
    input  logic            alu_ze,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [W-1:0]    out_result,
    output logic [REGW-1:0] out_dest,
    output logic            out_zero,
    output logic            out_cout,
    output logic            out_ovf_trap,
    output logic            out_illegal,
    output logic            ovf_sticky
);

    logic [2:0] dec_ctrl;
    ext_e       dec_ext;
    logic       dec_use_shamt;
    logic       dec_trap_en;
    logic       dec_illegal;

    s0_t  s0_d, s0_q;
    s1_t  s1_d, s1_q;
    logic s0_valid, s1_valid, sticky_q;
    logic s1_adv, accept;

    alu_decode u_decode (
        .op        (in_op),
        .funct     (in_funct),
        .ctrl      (dec_ctrl),
        .ext       (dec_ext),
        .use_shamt (dec_use_shamt),
        .trap_en   (dec_trap_en),
        .illegal   (dec_illegal)
    );

    assign s1_adv   = !s1_valid || out_ready;
    assign in_ready = !s0_valid || s1_adv;
    assign accept   = in_valid && in_ready;

    // Build the S0 payload (operands already selected/extended) from the ID fields
    always_comb begin
        s0_d         = '0;
        s0_d.dest    = in_dest;
        s0_d.illegal = dec_illegal;
        if (!dec_illegal) begin
            s0_d.ctrl    = dec_ctrl;
            s0_d.trap_en = dec_trap_en;
            if (dec_use_shamt) begin
                s0_d.a     = in_rt_val;
                s0_d.b     = '0;
                s0_d.shamt = in_shamt;
            end else begin
                s0_d.a = in_rs_val;
                case (dec_ext)
                    EXT_SEXT: s0_d.b = W'($signed(in_imm));
                    EXT_ZEXT: s0_d.b = W'(in_imm);
                    default:  s0_d.b = in_rt_val;
                endcase
            end
        end
    end

    // Capture ALU result and flags; illegal items carry zeroed result/flags
    always_comb begin
        s1_d          = '0;
        s1_d.dest     = s0_q.dest;
        s1_d.illegal  = s0_q.illegal;
        if (!s0_q.illegal) begin
            s1_d.result   = alu_r;
            s1_d.zero     = alu_ze;
            s1_d.cout     = alu_cout;
            s1_d.ovf_trap = alu_ovf && s0_q.trap_en;
        end
    end

    // Issue stage: load only on accept, empty when moved on or flushed
    always_ff @(posedge clk) begin
        if (reset) begin
            s0_valid <= 1'b0;
            s0_q     <= '0;
        end else if (flush) begin
            s0_valid <= 1'b0;
        end else if (accept) begin
            s0_valid <= 1'b1;
            s0_q     <= s0_d;
        end else if (s0_valid && s1_adv) begin
            s0_valid <= 1'b0;
        end
    end

    // Result stage: refill whenever downstream frees it
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
        end else if (flush) begin
            s1_valid <= 1'b0;
        end else if (s1_adv) begin
            s1_valid <= s0_valid;
            if (s0_valid) begin
                s1_q <= s1_d;
            end
        end
    end

    // Sticky overflow: set on a delivered trapping result, cleared only by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            sticky_q <= 1'b0;
        end else if (s1_valid && out_ready && s1_q.ovf_trap) begin
            sticky_q <= 1'b1;
        end
    end

    assign alu_ctrl     = s0_q.ctrl;
    assign alu_a        = s0_q.a;
    assign alu_b        = s0_q.b;
    assign alu_shamt    = s0_q.shamt;
    assign out_valid    = s1_valid;
    assign out_result   = s1_q.result;
    assign out_dest     = s1_q.dest;
    assign out_zero     = s1_q.zero;
    assign out_cout     = s1_q.cout;
    assign out_ovf_trap = s1_q.ovf_trap;
    assign out_illegal  = s1_q.illegal;
    assign ovf_sticky   = sticky_q;

endmodule

// File: tb/tb_alu_issue_unit.sv
// Testbench for alu_issue_unit with a behavioural ALU on the alu_* port.
module tb_alu_issue_unit;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, in_ready;
    logic [5:0]  in_op, in_funct;
    logic [31:0] in_rs_val, in_rt_val;
    logic [15:0] in_imm;
    logic [4:0]  in_shamt, in_dest;
    logic [2:0]  alu_ctrl;
    logic [31:0] alu_a, alu_b, alu_r;
    logic [4:0]  alu_shamt;
    logic        alu_cout, alu_ovf, alu_ze;
    logic        out_valid, out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_dest;
    logic        out_zero, out_cout, out_ovf_trap, out_illegal, ovf_sticky;

    int passed = 0;
    int total  = 0;
    logic sticky_exp = 1'b0;

    always #5 clk = ~clk;

    alu_issue_unit dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_funct(in_funct),
        .in_rs_val(in_rs_val), .in_rt_val(in_rt_val),
        .in_imm(in_imm), .in_shamt(in_shamt), .in_dest(in_dest),
        .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b), .alu_shamt(alu_shamt),
        .alu_r(alu_r), .alu_cout(alu_cout), .alu_ovf(alu_ovf), .alu_ze(alu_ze),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_dest(out_dest),
        .out_zero(out_zero), .out_cout(out_cout),
        .out_ovf_trap(out_ovf_trap), .out_illegal(out_illegal),
        .ovf_sticky(ovf_sticky)
    );

    // Behavioural ALU: 0 AND,1 OR,2 ADD,3 SLT,4 ADDU,5 SLL,6 SUB,7 SLTU
    logic [32:0] sum;
    always_comb begin
        sum      = '0;
        alu_r    = '0;
        alu_cout = 1'b0;
        alu_ovf  = 1'b0;
        case (alu_ctrl)
            3'd0: alu_r = alu_a & alu_b;
            3'd1: alu_r = alu_a | alu_b;
            3'd2, 3'd4: begin
                sum      = {1'b0, alu_a} + {1'b0, alu_b};
                alu_r    = sum[31:0];
                alu_cout = sum[32];
                alu_ovf  = (alu_a[31] == alu_b[31]) && (alu_r[31] != alu_a[31]);
            end
            3'd3: alu_r = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
            3'd5: alu_r = alu_a << alu_shamt;
            3'd6: begin
                sum      = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
                alu_r    = sum[31:0];
                alu_cout = sum[32];
                alu_ovf  = (alu_a[31] != alu_b[31]) && (alu_r[31] != alu_a[31]);
            end
            default: alu_r = (alu_a < alu_b) ? 32'd1 : 32'd0;
        endcase
        alu_ze = (alu_r == 32'd0);
    end

    typedef struct {
        logic [5:0]  op;
        logic [5:0]  funct;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [15:0] imm;
        logic [4:0]  shamt;
        logic [4:0]  dest;
        logic [2:0]  ctrl;
        logic [31:0] res;
        logic [3:0]  flags;   // {zero, cout, trap, illegal}
    } vec_t;

    localparam int NV = 19;
    vec_t vecs[NV];

    function automatic vec_t mk(input logic [5:0] op, input logic [5:0] fn,
                                input logic [31:0] rs, input logic [31:0] rt,
                                input logic [15:0] imm, input logic [4:0] sh,
                                input logic [4:0] dest, input logic [2:0] ctrl,
                                input logic [31:0] res, input logic [3:0] flags);
        vec_t v;
        v.op = op; v.funct = fn; v.rs = rs; v.rt = rt; v.imm = imm; v.shamt = sh;
        v.dest = dest; v.ctrl = ctrl; v.res = res; v.flags = flags;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else passed++;
    endtask

    task automatic drive(input vec_t v);
        in_op = v.op; in_funct = v.funct; in_rs_val = v.rs; in_rt_val = v.rt;
        in_imm = v.imm; in_shamt = v.shamt; in_dest = v.dest;
    endtask

    task automatic garbage();
        in_op = 6'h3F; in_funct = 6'h3F; in_rs_val = 32'hDEADBEEF; in_rt_val = 32'hCAFEF00D;
        in_imm = 16'h5A5A; in_shamt = 5'd31; in_dest = 5'd31;
    endtask

    // One isolated instruction: accept, check S0 and N+2 latency, deliver
    task automatic run_vec(input vec_t v, input int k);
        @(posedge clk); #1;
        drive(v); in_valid = 1'b1; out_ready = 1'b1;
        #1 chk($sformatf("v%0d_in_ready", k), 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0; garbage();
        chk($sformatf("v%0d_lat1_valid", k), 64'(out_valid), 64'd0);
        chk($sformatf("v%0d_alu_ctrl", k), 64'(alu_ctrl), 64'(v.ctrl));
        @(posedge clk); #1;
        chk($sformatf("v%0d_out_valid", k), 64'(out_valid), 64'd1);
        chk($sformatf("v%0d_result", k), 64'(out_result), 64'(v.res));
        chk($sformatf("v%0d_flags", k),
            64'({out_zero, out_cout, out_ovf_trap, out_illegal}), 64'(v.flags));
        chk($sformatf("v%0d_dest", k), 64'(out_dest), 64'(v.dest));
        if (v.flags[1]) sticky_exp = 1'b1;
        @(posedge clk); #1;
        chk($sformatf("v%0d_drained", k), 64'(out_valid), 64'd0);
        chk($sformatf("v%0d_sticky", k), 64'(ovf_sticky), 64'(sticky_exp));
    endtask

    initial begin
        //            op     funct  rs            rt            imm      sh  dst ctrl res           {z,c,t,i}
        vecs[0]  = mk(6'h00, 6'h21, 32'h7FFFFFFF, 32'h00000001, 16'h0,   0, 1,  4, 32'h80000000, 4'b0000); // ADDU
        vecs[1]  = mk(6'h00, 6'h20, 32'h7FFFFFFF, 32'h00000001, 16'h0,   0, 2,  2, 32'h80000000, 4'b0010); // ADD trap
        vecs[2]  = mk(6'h00, 6'h23, 32'h00000000, 32'h00000001, 16'h0,   0, 3,  6, 32'hFFFFFFFF, 4'b0000); // SUBU
        vecs[3]  = mk(6'h0C, 6'h00, 32'hFFFFFFFF, 32'h12345678, 16'hFFFF,0, 4,  0, 32'h0000FFFF, 4'b0000); // ANDI
        vecs[4]  = mk(6'h0A, 6'h00, 32'hFFFFFFFE, 32'h0,        16'hFFFF,0, 5,  3, 32'h00000001, 4'b0000); // SLTI
        vecs[5]  = mk(6'h00, 6'h00, 32'h12345678, 32'h0000000F, 16'h0,   4, 6,  5, 32'h000000F0, 4'b0000); // SLL
        vecs[6]  = mk(6'h3F, 6'h00, 32'h11111111, 32'h22222222, 16'h1,   0, 7,  0, 32'h00000000, 4'b0001); // illegal op
        vecs[7]  = mk(6'h04, 6'h00, 32'h00000005, 32'h00000005, 16'h0,   0, 8,  6, 32'h00000000, 4'b1100); // BEQ eq
        vecs[8]  = mk(6'h05, 6'h00, 32'h00000005, 32'h00000006, 16'h0,   0, 9,  6, 32'hFFFFFFFF, 4'b0000); // BNE
        vecs[9]  = mk(6'h00, 6'h22, 32'h80000000, 32'h00000001, 16'h0,   0, 10, 6, 32'h7FFFFFFF, 4'b0110); // SUB trap
        vecs[10] = mk(6'h08, 6'h00, 32'h7FFFFFFF, 32'h0,        16'h0001,0, 11, 2, 32'h80000000, 4'b0010); // ADDI trap
        vecs[11] = mk(6'h09, 6'h00, 32'h7FFFFFFF, 32'h0,        16'hFFFF,0, 12, 4, 32'h7FFFFFFE, 4'b0100); // ADDIU
        vecs[12] = mk(6'h0D, 6'h00, 32'hF0000000, 32'h0,        16'h8001,0, 13, 1, 32'hF0008001, 4'b0000); // ORI zext
        vecs[13] = mk(6'h0B, 6'h00, 32'h00000001, 32'h0,        16'hFFFF,0, 14, 7, 32'h00000001, 4'b0000); // SLTIU
        vecs[14] = mk(6'h00, 6'h2A, 32'hFFFFFFFF, 32'h00000001, 16'h0,   0, 15, 3, 32'h00000001, 4'b0000); // SLT
        vecs[15] = mk(6'h00, 6'h2B, 32'hFFFFFFFF, 32'h00000001, 16'h0,   0, 16, 7, 32'h00000000, 4'b1000); // SLTU
        vecs[16] = mk(6'h00, 6'h3F, 32'h11111111, 32'h22222222, 16'h0,   0, 17, 0, 32'h00000000, 4'b0001); // illegal funct
        vecs[17] = mk(6'h00, 6'h25, 32'h0F0F0000, 32'h0000F0F0, 16'h0,   0, 18, 1, 32'h0F0FF0F0, 4'b0000); // OR
        vecs[18] = mk(6'h00, 6'h24, 32'hFF00FF00, 32'h0FF00FF0, 16'h0,   0, 19, 0, 32'h0F000F00, 4'b0000); // AND

        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        garbage();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_payload", 64'({out_result, out_dest, out_zero, out_cout, out_ovf_trap, out_illegal}), 64'd0);
        chk("rst_alu", 64'({alu_ctrl, alu_a, alu_shamt}), 64'd0);
        chk("rst_alu_b", 64'(alu_b), 64'd0);
        chk("rst_sticky", 64'(ovf_sticky), 64'd0);

        for (int k = 0; k < NV; k++) run_vec(vecs[k], k);

        // Backpressure: 4 back-to-back ADDIU, out_ready low for 3 cycles
        begin
            int idx = 0, got = 0;
            logic        stalled = 1'b0;
            logic [36:0] held = '0;
            vec_t bp;
            for (int cyc = 0; cyc < 30 && got < 4; cyc++) begin
                @(posedge clk); #1;
                out_ready = (cyc >= 3);
                in_valid  = (idx < 4);
                if (idx < 4) begin
                    bp = mk(6'h09, 6'h00, 32'(idx * 16), 32'h0, 16'h0003, 0,
                            5'(idx + 1), 4, 32'(idx * 16 + 3), 4'b0000);
                    drive(bp);
                end else garbage();
                #1;
                if (stalled) begin
                    chk($sformatf("bp_hold_c%0d", cyc),
                        64'({out_valid, out_result, out_dest}), 64'({1'b1, held}));
                end
                if (cyc == 2) chk("bp_in_ready_low", 64'(in_ready), 64'd0);
                if (cyc == 3) chk("bp_in_ready_back", 64'(in_ready), 64'd1);
                if (out_valid && out_ready) begin
                    chk($sformatf("bp_res%0d", got),
                        64'({out_result, out_dest}), 64'({32'(got * 16 + 3), 5'(got + 1)}));
                    got++;
                end
                stalled = out_valid && !out_ready;
                held    = {out_result, out_dest};
                if (in_valid && in_ready) idx++;
            end
            chk("bp_all_delivered", 64'(got), 64'd4);
            @(posedge clk); #1;
            in_valid = 1'b0;
        end

        // Flush with S0 and S1 both full, ID still offering
        @(posedge clk); #1;
        out_ready = 1'b0; drive(vecs[0]); in_valid = 1'b1;
        @(posedge clk); #1;
        drive(vecs[1]);
        @(posedge clk); #1;
        chk("fl_full_valid", 64'(out_valid), 64'd1);
        drive(vecs[2]); flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        chk("fl_in_ready", 64'(in_ready), 64'd1);
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("fl_no_valid%0d", c), 64'(out_valid), 64'd0);
            @(posedge clk); #1;
        end
        chk("fl_sticky_kept", 64'(ovf_sticky), 64'(sticky_exp));

        // Flush on the same cycle as an accept into an empty pipe
        drive(vecs[17]); in_valid = 1'b1; flush = 1'b1;
        #1 chk("fl_acc_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("fl_acc_no_valid%0d", c), 64'(out_valid), 64'd0);
            @(posedge clk); #1;
        end

        // Reset mid-stream
        out_ready = 1'b0; drive(vecs[1]); in_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1; sticky_exp = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("rs_no_valid%0d", c), 64'(out_valid), 64'd0);
            @(posedge clk); #1;
        end
        chk("rs_sticky_clear", 64'(ovf_sticky), 64'd0);
        chk("rs_alu_clear", 64'({alu_ctrl, alu_a}), 64'd0);
        run_vec(vecs[1], 100);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
